simd_lsu: RTL and testbench
===========================

Name: simd_lsu

Overview:
- Parametrised vector load/store unit between the SIMD datapath M-stage and the wide data RAM.
- Generalises the fixed 256-bit, single-cycle memory path to configurable lane count, lane width and RAM read latency.
- Adds scalar (single-lane) and masked vector accesses.
- Provides a registered request/response handshake and a pipeline stall output.

Parameters:
- LANES, 8, number of SIMD lanes.
- LANE_W, 32, bits per lane; must be a multiple of 8.
- ADDR_W, 32, byte-address width.
- RD_LAT, 2, RAM read latency in cycles, counted from the rden_RAM cycle to valid readData_RAM; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_scalar  in  1  1 = single-lane access, 0 = full-line vector access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  LANES*LANE_W  store data; scalar stores use lane 0.
- req_mask  in  LANES  per-lane enable; vector accesses only.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  LANES*LANE_W  load result.
- resp_err  out  1  misaligned request rejected.
- stall_o  out  1  hold the pipeline.
- address_RAM  out  32  line index.
- byteena_RAM  out  LANES*LANE_W/8  byte enables.
- readData_RAM  in  LANES*LANE_W  RAM read data.
- writeData_RAM  out  LANES*LANE_W  RAM write data.
- rden_RAM  out  1  RAM read enable.
- wren_RAM  out  1  RAM write enable.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: every output is 0 and the FSM is in IDLE.
- Reset in any state aborts the operation:
  - next cycle is IDLE with all outputs 0;
  - in-flight RAM read data is discarded;
  - no resp_valid is produced.
- Address geometry:
  - LINE_B = LANES*LANE_W/8, LANE_B = LANE_W/8.
  - address_RAM = req_addr >> log2(LINE_B).
  - Scalar lane index = (req_addr >> log2(LANE_B)) mod LANES.
- Handshake:
  - req_ready = 1 only in IDLE.
  - Accept occurs at cycle T when req_valid && req_ready.
  - At accept, address, data, mask, lane and type are registered.
  - The requester holds req_valid until resp_valid.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
  - IDLE -> WR on an accepted store.
  - IDLE -> RD_ISSUE on an accepted load.
  - WR -> IDLE.
  - RD_ISSUE -> RD_WAIT, loading a counter with RD_LAT.
  - RD_WAIT -> RD_RESP when the counter reaches 0; readData_RAM is captured on that edge.
  - RD_RESP -> IDLE.
- Store timing:
  - In T+1 (WR), wren_RAM = 1 for exactly one cycle, and address_RAM, writeData_RAM and byteena_RAM are driven from registers.
  - resp_valid = 1 in T+1.
  - Vector store: writeData_RAM = req_wdata; byteena = each mask bit expanded to LANE_B bits.
  - Scalar store: lane 0 data is replicated into the selected lane; only that lane's LANE_B enable bits are set.
  - If byteena is all zero (mask == 0), wren_RAM stays 0 but resp_valid still pulses in T+1.
- Load timing:
  - rden_RAM = 1 in T+1 only.
  - Data is captured at T+1+RD_LAT.
  - resp_valid = 1 in T+2+RD_LAT.
  - Next accept is possible at T+3+RD_LAT.
- Load data:
  - Vector load: masked-off lanes return 0.
  - Scalar load: the selected lane is placed in lane 0; all other lanes return 0.
  - Mask == 0 vector load still issues rden_RAM and returns all zeros.
- resp_rdata is held until the next resp_valid.
- stall_o = (IDLE && req_valid) || (state not in {IDLE, WR, RD_RESP}).
  - stall_o is low in the resp_valid cycle, so the pipeline advances on completion.
- req_valid outside IDLE is ignored.

Optional Feature:
- Macro: SIMD_LSU_ALIGN_CHK_EN.
- A request is misaligned when:
  - vector access and req_addr mod LINE_B != 0; or
  - scalar access and req_addr mod LANE_B != 0.
- Defined: a misaligned request is accepted but causes no RAM access (rden_RAM and wren_RAM stay 0).
  - resp_valid = 1 and resp_err = 1 in T+1; resp_rdata = 0.
- Undefined: low address bits are ignored (access is aligned down); resp_err is tied to 0.

Decomposition:
- Package simd_lsu_pkg:
  - FSM state enum;
  - functions line_bytes(LANES, LANE_W) and lane_bytes(LANE_W);
  - RD_LAT counter width, $clog2(RD_LAT+1).
- Sub-module simd_lsu_lane_mux (combinational):
  - lane select and replicate;
  - mask-to-byteena expansion;
  - load extract and zero-fill.

Test Plan (LANES=8, LANE_W=32, RD_LAT=2):
- Vector store: addr 0x40, mask 0xFF -> in T+1, wren_RAM=1, address_RAM=2, byteena=0xFFFFFFFF, resp_valid=1; req_ready=1 in T+2.
- Scalar store: addr 0x4C, wdata[31:0]=0xDEADBEEF -> byteena=0x0000F000; writeData_RAM lane 3 = 0xDEADBEEF.
- Vector load: addr 0x40, mask 0x0F, RAM line lanes = 0x11..0x88 -> rden_RAM in T+1; resp_valid in T+4 with lanes 0-3 = RAM data and lanes 4-7 = 0; stall_o high T..T+3, low in T+4.
- Scalar load: addr 0x5C -> address_RAM=2, lane 7; resp_rdata[31:0] = RAM lane 7, remaining bits 0.
- Reset asserted at T+2 of a load -> T+3 all outputs 0, FSM in IDLE, no resp_valid ever; new request accepted in T+3.
- Zero-mask store -> wren_RAM never high; resp_valid in T+1.
- With SIMD_LSU_ALIGN_CHK_EN: vector load at 0x44 -> no rden_RAM; resp_err=1 and resp_valid=1 in T+1.

Source files
------------

// File: rtl/simd_lsu_pkg.sv
// Shared types and geometry helpers for the SIMD vector load/store unit.
// Optional feature macro: SIMD_LSU_ALIGN_CHK_EN (misaligned-request rejection).
package simd_lsu_pkg;

    // Control FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_RESP
    } lsu_state_t;

    // Bytes in one full RAM line
    function automatic int line_bytes(input int lanes, input int lane_w);
        return (lanes * lane_w) / 8;
    endfunction

    // Bytes in one SIMD lane
    function automatic int lane_bytes(input int lane_w);
        return lane_w / 8;
    endfunction

    // Width of the read-latency down-counter
    function automatic int rd_cnt_w(input int rd_lat);
        return $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/simd_lsu_lane_mux.sv
// Combinational lane steering for the SIMD load/store unit: store-side lane
// replicate plus byte-enable expansion, load-side lane extract and zero-fill.
// LANES is assumed to be a power of two.
module simd_lsu_lane_mux
    import simd_lsu_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int LANE_W     = 32,
    parameter int LANE_IDX_W = 3
) (
    input  logic                        i_st_scalar,
    input  logic [LANE_IDX_W-1:0]       i_st_lane,
    input  logic [LANES-1:0]            i_st_mask,
    input  logic [LANES*LANE_W-1:0]     i_st_wdata,
    output logic [LANES*LANE_W-1:0]     o_st_wdata,
    output logic [LANES*LANE_W/8-1:0]   o_st_byteena,
    input  logic                        i_ld_scalar,
    input  logic [LANE_IDX_W-1:0]       i_ld_lane,
    input  logic [LANES-1:0]            i_ld_mask,
    input  logic [LANES*LANE_W-1:0]     i_ld_rdata,
    output logic [LANES*LANE_W-1:0]     o_ld_rdata
);

    localparam int LANE_B = lane_bytes(LANE_W);

    logic [LANE_W-1:0] w_scalar_lane;

    // The lane picked by a scalar load, later moved down to lane 0
    assign w_scalar_lane = i_ld_rdata[i_ld_lane*LANE_W +: LANE_W];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic w_st_sel;

        // A scalar store enables only its own lane; a vector store follows the mask
        assign w_st_sel = i_st_scalar ? (i_st_lane == LANE_IDX_W'(gi)) : i_st_mask[gi];

        // Scalar data is replicated everywhere; the byte enables restrict the write
        assign o_st_wdata[gi*LANE_W +: LANE_W] = i_st_scalar ? i_st_wdata[LANE_W-1:0]
                                                             : i_st_wdata[gi*LANE_W +: LANE_W];
        assign o_st_byteena[gi*LANE_B +: LANE_B] = {LANE_B{w_st_sel}};

        if (gi == 0) begin : g_lane0
            // Lane 0 carries the scalar result or its own masked vector data
            assign o_ld_rdata[LANE_W-1:0] = i_ld_scalar ? w_scalar_lane :
                                            (i_ld_mask[0] ? i_ld_rdata[LANE_W-1:0] : '0);
        end else begin : g_lane_n
            // Upper lanes are zero for scalar loads and for masked-off vector lanes
            assign o_ld_rdata[gi*LANE_W +: LANE_W] = (!i_ld_scalar && i_ld_mask[gi]) ?
                                                     i_ld_rdata[gi*LANE_W +: LANE_W] : '0;
        end
    end

endmodule

// File: rtl/simd_lsu.sv
// SIMD vector load/store unit between the datapath M-stage and the wide data RAM.
// Supports vector (masked) and scalar accesses with a configurable RAM read latency.
// Optional feature macro: SIMD_LSU_ALIGN_CHK_EN rejects misaligned requests with resp_err.
module simd_lsu
    import simd_lsu_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic                       req_scalar,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [LANES*LANE_W-1:0]    req_wdata,
    input  logic [LANES-1:0]           req_mask,
    output logic                       resp_valid,
    output logic [LANES*LANE_W-1:0]    resp_rdata,
    output logic                       resp_err,
    output logic                       stall_o,
    output logic [31:0]                address_RAM,
    output logic [LANES*LANE_W/8-1:0]  byteena_RAM,
    input  logic [LANES*LANE_W-1:0]    readData_RAM,
    output logic [LANES*LANE_W-1:0]    writeData_RAM,
    output logic                       rden_RAM,
    output logic                       wren_RAM
);

    localparam int DATA_W     = LANES * LANE_W;
    localparam int LINE_B     = line_bytes(LANES, LANE_W);
    localparam int LANE_B     = lane_bytes(LANE_W);
    localparam int LINE_SH    = $clog2(LINE_B);
    localparam int LANE_SH    = $clog2(LANE_B);
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W      = rd_cnt_w(RD_LAT);

    lsu_state_t              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_scalar;
    logic [LANE_IDX_W-1:0]   r_lane;
    logic [LANES-1:0]        r_mask;
    logic [31:0]             r_address;
    logic [DATA_W/8-1:0]     r_byteena;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_rden;
    logic                    r_wren;
    logic                    r_resp_valid;

    logic [LANE_IDX_W-1:0]   w_lane;
    logic [31:0]             w_line;
    logic                    w_misaligned;
    logic [DATA_W-1:0]       w_st_wdata;
    logic [DATA_W/8-1:0]     w_st_byteena;
    logic [DATA_W-1:0]       w_ld_rdata;

    // Address geometry: low bits beyond the line/lane granule are simply dropped
    assign w_line = 32'(req_addr >> LINE_SH);
    assign w_lane = LANE_IDX_W'(req_addr >> LANE_SH);

`ifdef SIMD_LSU_ALIGN_CHK_EN
    logic r_resp_err;

    // Misaligned means any offset inside the access granule
    assign w_misaligned = req_scalar ? ((req_addr & ADDR_W'(LANE_B - 1)) != '0)
                                     : ((req_addr & ADDR_W'(LINE_B - 1)) != '0);
    assign resp_err     = r_resp_err;
`else
    assign w_misaligned = 1'b0;
    assign resp_err     = 1'b0;
`endif

    simd_lsu_lane_mux #(
        .LANES      (LANES),
        .LANE_W     (LANE_W),
        .LANE_IDX_W (LANE_IDX_W)
    ) u_lane_mux (
        .i_st_scalar  (req_scalar),
        .i_st_lane    (w_lane),
        .i_st_mask    (req_mask),
        .i_st_wdata   (req_wdata),
        .o_st_wdata   (w_st_wdata),
        .o_st_byteena (w_st_byteena),
        .i_ld_scalar  (r_scalar),
        .i_ld_lane    (r_lane),
        .i_ld_mask    (r_mask),
        .i_ld_rdata   (readData_RAM),
        .o_ld_rdata   (w_ld_rdata)
    );

    // Control FSM with registered RAM-side and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_scalar     <= 1'b0;
            r_lane       <= '0;
            r_mask       <= '0;
            r_address    <= '0;
            r_byteena    <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_rden       <= 1'b0;
            r_wren       <= 1'b0;
            r_resp_valid <= 1'b0;
`ifdef SIMD_LSU_ALIGN_CHK_EN
            r_resp_err   <= 1'b0;
`endif
        end else begin
            // Strobes default low so each one lasts a single cycle
            r_rden       <= 1'b0;
            r_wren       <= 1'b0;
            r_resp_valid <= 1'b0;
`ifdef SIMD_LSU_ALIGN_CHK_EN
            r_resp_err   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_scalar  <= req_scalar;
                        r_lane    <= w_lane;
                        r_mask    <= req_mask;
                        r_address <= w_line;
                        if (w_misaligned) begin
                            // Rejected: no RAM traffic, immediate error response
                            r_rdata      <= '0;
                            r_resp_valid <= 1'b1;
`ifdef SIMD_LSU_ALIGN_CHK_EN
                            r_resp_err   <= 1'b1;
`endif
                            r_state      <= S_WR;
                        end else if (req_we) begin
                            r_wdata      <= w_st_wdata;
                            r_byteena    <= w_st_byteena;
                            r_wren       <= |w_st_byteena;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_WR;
                        end else begin
                            r_rden  <= 1'b1;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                S_WR: begin
                    r_state <= S_IDLE;
                end
                S_RD_ISSUE: begin
                    // Counter holds remaining RD_WAIT cycles; zero means data is valid now
                    r_cnt   <= CNT_W'(RD_LAT - 1);
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata      <= w_ld_rdata;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RD_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RD_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready only when idle and not being reset; stall while a request waits or a read is in flight
    assign req_ready = (r_state == S_IDLE) && !reset;
    assign stall_o   = ((r_state == S_IDLE) && req_valid) ||
                       (r_state == S_RD_ISSUE) || (r_state == S_RD_WAIT);

    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_rdata;
    assign address_RAM   = r_address;
    assign byteena_RAM   = r_byteena;
    assign writeData_RAM = r_wdata;
    assign rden_RAM      = r_rden;
    assign wren_RAM      = r_wren;

endmodule

// File: tb/tb_simd_lsu.sv
// Self-checking bench for simd_lsu (LANES=8, LANE_W=32, RD_LAT=2): table of
// directed vectors, a reset-abort sequence, and random traffic checked against
// a byte-addressed reference memory.
module tb_simd_lsu;

    localparam int RD_LAT = 2;
    localparam logic [255:0] JUNK = {8{32'hBAD0CAFE}};

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic         req_scalar;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic [7:0]   req_mask;
    logic         resp_valid;
    logic [255:0] resp_rdata;
    logic         resp_err;
    logic         stall_o;
    logic [31:0]  address_RAM;
    logic [31:0]  byteena_RAM;
    logic [255:0] readData_RAM;
    logic [255:0] writeData_RAM;
    logic         rden_RAM;
    logic         wren_RAM;

    int n_vec = 0;
    int n_bad = 0;

    bit [255:0] ram [0:15];
    bit [RD_LAT-1:0] pv;
    bit [3:0] pa [0:RD_LAT-1];
    bit [7:0] ref_mem [0:511];

    typedef struct {
        bit           we;
        bit           sc;
        logic [31:0]  addr;
        logic [255:0] wd;
        logic [7:0]   mk;
        logic [31:0]  line;
        logic [31:0]  be;
        logic [255:0] wdm;
        logic [255:0] rd;
    } vec_t;

    vec_t tbl [8];

    simd_lsu #(.LANES(8), .LANE_W(32), .ADDR_W(32), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_scalar    (req_scalar),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_mask      (req_mask),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .stall_o       (stall_o),
        .address_RAM   (address_RAM),
        .byteena_RAM   (byteena_RAM),
        .readData_RAM  (readData_RAM),
        .writeData_RAM (writeData_RAM),
        .rden_RAM      (rden_RAM),
        .wren_RAM      (wren_RAM)
    );

    always #5 clk = ~clk;

    // Wide RAM: byte-enabled writes, reads valid exactly RD_LAT cycles after rden
    always @(posedge clk) begin
        if (wren_RAM) begin
            for (int b = 0; b < 32; b++)
                if (byteena_RAM[b]) ram[address_RAM[3:0]][b*8 +: 8] <= writeData_RAM[b*8 +: 8];
        end
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        pv[0] <= rden_RAM;
        pa[0] <= address_RAM[3:0];
    end

    assign readData_RAM = pv[RD_LAT-1] ? ram[pa[RD_LAT-1]] : JUNK;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] be_mask(input logic [31:0] be);
        logic [255:0] m;
        for (int i = 0; i < 32; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Reference model on a flat byte memory: returns byte enables/data a store must
    // drive and the data a load must return, and applies stores to the memory.
    task automatic model(input bit we, input bit sc, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [7:0] mk,
                         output logic [31:0] be, output logic [255:0] wdm,
                         output logic [255:0] rd);
        int base;
        int off;
        be = '0; wdm = '0; rd = '0;
        if (sc) begin
            base = int'(addr & ~32'd3);
            off  = base % 32;
            for (int b = 0; b < 4; b++) begin
                if (we) begin
                    ref_mem[base+b]       = wd[b*8 +: 8];
                    be[off+b]             = 1'b1;
                    wdm[(off+b)*8 +: 8]   = wd[b*8 +: 8];
                end else begin
                    rd[b*8 +: 8] = ref_mem[base+b];
                end
            end
        end else begin
            base = int'(addr & ~32'd31);
            for (int i = 0; i < 32; i++) begin
                if (mk[i/4]) begin
                    if (we) begin
                        ref_mem[base+i] = wd[i*8 +: 8];
                        be[i]           = 1'b1;
                        wdm[i*8 +: 8]   = wd[i*8 +: 8];
                    end else begin
                        rd[i*8 +: 8] = ref_mem[base+i];
                    end
                end
            end
        end
    endtask

    // Issue one request (caller is just after a negedge) and check its full timeline
    task automatic apply(input string nm, input bit we, input bit sc, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [7:0] mk, input bit exp_err,
                         input logic [31:0] e_line, input logic [31:0] e_be,
                         input logic [255:0] e_wdm, input logic [255:0] e_rd);
        int resp_cyc = 0, wren_cyc = 0, wren_n = 0, rden_cyc = 0, rden_n = 0, exp_resp;
        logic [31:0]  g_line = '0;
        logic [31:0]  g_be = '0;
        logic [255:0] g_wd = '0;
        logic [255:0] g_rd = '0;
        logic         g_err = 1'b0;
        bit           stall_bad = 1'b0;
        bit           exp_st;
        req_valid = 1'b1; req_we = we; req_scalar = sc; req_addr = addr;
        req_wdata = wd; req_mask = mk;
        #1;
        chk({nm, " ready@T"}, req_ready, 1'b1);
        chk({nm, " stall@T"}, stall_o, 1'b1);
        for (int c = 1; c <= 30 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (wren_RAM) begin
                wren_n++;
                if (wren_cyc == 0) begin
                    wren_cyc = c; g_line = address_RAM; g_be = byteena_RAM; g_wd = writeData_RAM;
                end
            end
            if (rden_RAM) begin
                rden_n++;
                if (rden_cyc == 0) begin rden_cyc = c; g_line = address_RAM; end
            end
            exp_st = !we && !exp_err && (c <= 1 + RD_LAT);
            if (stall_o !== exp_st) stall_bad = 1'b1;
            if (resp_valid) begin
                resp_cyc = c; g_rd = resp_rdata; g_err = resp_err; req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        exp_resp = (exp_err || we) ? 1 : 2 + RD_LAT;
        chk({nm, " resp_cycle"}, resp_cyc, exp_resp);
        chk({nm, " resp_err"}, g_err, exp_err);
        chk({nm, " stall_trace_bad"}, stall_bad, 1'b0);
        if (exp_err) begin
            chk({nm, " rden_count"}, rden_n, 0);
            chk({nm, " wren_count"}, wren_n, 0);
            chk({nm, " rdata"}, g_rd, '0);
        end else if (we) begin
            chk({nm, " rden_count"}, rden_n, 0);
            chk({nm, " wren_count"}, wren_n, (e_be != 0) ? 1 : 0);
            if (e_be != 0) begin
                chk({nm, " wren_cycle"}, wren_cyc, 1);
                chk({nm, " address"}, g_line, e_line);
                chk({nm, " byteena"}, g_be, e_be);
                chk({nm, " wdata"}, g_wd & be_mask(e_be), e_wdm);
            end
        end else begin
            chk({nm, " rden_count"}, rden_n, 1);
            chk({nm, " rden_cycle"}, rden_cyc, 1);
            chk({nm, " address"}, g_line, e_line);
            chk({nm, " wren_count"}, wren_n, 0);
            chk({nm, " rdata"}, g_rd, e_rd);
        end
        @(negedge clk);
        chk({nm, " ready_after"}, req_ready, 1'b1);
        chk({nm, " resp_after"}, resp_valid, 1'b0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " address_RAM"}, address_RAM, '0);
        chk({nm, " byteena_RAM"}, byteena_RAM, '0);
        chk({nm, " writeData_RAM"}, writeData_RAM, '0);
        chk({nm, " rden_RAM"}, rden_RAM, 1'b0);
        chk({nm, " wren_RAM"}, wren_RAM, 1'b0);
        chk({nm, " resp_valid"}, resp_valid, 1'b0);
        chk({nm, " resp_rdata"}, resp_rdata, '0);
        chk({nm, " resp_err"}, resp_err, 1'b0);
        chk({nm, " stall_o"}, stall_o, 1'b0);
    endtask

    initial begin
        logic [31:0]  m_be;
        logic [255:0] m_wdm, m_rd, wd;
        logic [31:0]  addr;
        bit           we, sc;
        logic [7:0]   mk;

        tbl[0] = '{we:1, sc:0, addr:32'h40,
                   wd:256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011,
                   mk:8'hFF, line:32'd2, be:32'hFFFFFFFF,
                   wdm:256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011,
                   rd:'0};
        tbl[1] = '{we:0, sc:0, addr:32'h40, wd:'0, mk:8'h0F, line:32'd2, be:'0, wdm:'0,
                   rd:256'h00000000_00000000_00000000_00000000_00000044_00000033_00000022_00000011};
        tbl[2] = '{we:0, sc:1, addr:32'h5C, wd:'0, mk:8'h00, line:32'd2, be:'0, wdm:'0,
                   rd:256'h88};
        tbl[3] = '{we:1, sc:1, addr:32'h4C,
                   wd:{{7{32'hA5A5A5A5}}, 32'hDEADBEEF},
                   mk:8'h00, line:32'd2, be:32'h0000F000,
                   wdm:256'h00000000_00000000_00000000_00000000_DEADBEEF_00000000_00000000_00000000,
                   rd:'0};
        tbl[4] = '{we:0, sc:1, addr:32'h4C, wd:'0, mk:8'hFF, line:32'd2, be:'0, wdm:'0,
                   rd:256'hDEADBEEF};
        tbl[5] = '{we:1, sc:0, addr:32'h80, wd:{8{32'h12345678}}, mk:8'h00, line:32'd4,
                   be:32'h0, wdm:'0, rd:'0};
        tbl[6] = '{we:0, sc:0, addr:32'h40, wd:'0, mk:8'h00, line:32'd2, be:'0, wdm:'0, rd:'0};
        tbl[7] = '{we:0, sc:0, addr:32'h40, wd:'0, mk:8'hFF, line:32'd2, be:'0, wdm:'0,
                   rd:256'h00000088_00000077_00000066_00000055_DEADBEEF_00000033_00000022_00000011};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_scalar = 1'b0;
        req_addr = '0; req_wdata = '0; req_mask = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset req_ready", req_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            model(tbl[i].we, tbl[i].sc, tbl[i].addr, tbl[i].wd, tbl[i].mk, m_be, m_wdm, m_rd);
            apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].sc, tbl[i].addr, tbl[i].wd, tbl[i].mk,
                  1'b0, tbl[i].line, tbl[i].be, tbl[i].wdm, tbl[i].rd);
            $display("vec%0d we=%0d scalar=%0d addr=%h mask=%h done", i, tbl[i].we, tbl[i].sc,
                     tbl[i].addr, tbl[i].mk);
        end

        // Reset at T+2 of a load aborts it; a new request is accepted in T+3
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_scalar = 1'b0; req_addr = 32'h40; req_mask = 8'hFF;
        @(negedge clk);
        chk("rstseq rden@T+1", rden_RAM, 1'b1);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("rstseq T+3");
        chk("rstseq ready@T+3", req_ready, 1'b1);
        model(1'b0, 1'b1, 32'h5C, '0, 8'h00, m_be, m_wdm, m_rd);
        apply("rstseq next", 1'b0, 1'b1, 32'h5C, '0, 8'h00, 1'b0, 32'd2, '0, '0, m_rd);
        $display("rstseq reset-abort then scalar load 0x5C done");

`ifdef SIMD_LSU_ALIGN_CHK_EN
        apply("misalign", 1'b0, 1'b0, 32'h44, '0, 8'hFF, 1'b1, '0, '0, '0, '0);
        $display("misalign vector load 0x44 done");
`endif

        // Random traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            we   = $urandom_range(0, 1);
            sc   = $urandom_range(0, 1);
            addr = $urandom_range(0, 511);
`ifdef SIMD_LSU_ALIGN_CHK_EN
            addr = sc ? (addr & ~32'd3) : (addr & ~32'd31);
`endif
            for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom;
            mk = 8'($urandom);
            model(we, sc, addr, wd, mk, m_be, m_wdm, m_rd);
            apply($sformatf("rnd%0d", i), we, sc, addr, wd, mk, 1'b0, addr >> 5, m_be, m_wdm, m_rd);
            $display("rnd%0d we=%0d scalar=%0d addr=%h mask=%h done", i, we, sc, addr, mk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
